// File: rtl/pipe_stream_egress_pkg.sv
// Shared types for the pipeline egress skid buffer: the buffer occupancy state
// and small decode helpers used by the egress block.
package rtl_utils;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } egress_state_e;

    localparam int EGRESS_DEPTH = 2;

    // Upstream may shift whenever a free slot is guaranteed for this edge.
    function automatic logic egress_can_accept(input egress_state_e st);
        return (st != ST_FULL);
    endfunction

    function automatic logic egress_has_data(input egress_state_e st);
        return (st != ST_EMPTY);
    endfunction

endpackage : rtl_utils

// File: rtl/pipe_stream_egress_if.sv
// Bundle of the upstream-pipeline tap and the downstream valid/ready stream
// around the egress buffer; master is the egress side, slave its environment.
interface pipe_stream_egress_if #(
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1
);
    logic [DATA_W-1:0]   pipe_data;
    logic [STATUS_W-1:0] pipe_status;
    logic                pipe_shift_en;
    logic                m_valid;
    logic                m_ready;
    logic [DATA_W-1:0]   m_data;
    logic [STATUS_W-1:0] m_status;

    modport master (
        input  pipe_data, pipe_status, m_ready,
        output pipe_shift_en, m_valid, m_data, m_status
    );

    modport slave (
        output pipe_data, pipe_status, m_ready,
        input  pipe_shift_en, m_valid, m_data, m_status
    );
endinterface : pipe_stream_egress_if

// File: rtl/pipe_stream_egress.sv
// Two-entry skid buffer between an enable-shift pipeline's final stage and a
// valid/ready stream; shift enable depends only on registered occupancy.
module pipe_stream_egress
    import rtl_utils::*;
#(
    parameter int DATA_W   = 32,
    parameter int STATUS_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   pipe_data_i,
    input  logic [STATUS_W-1:0] pipe_status_i,
    output logic                pipe_shift_en_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [DATA_W-1:0]   m_data_o,
    output logic [STATUS_W-1:0] m_status_o
);

    egress_state_e       state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, skid_data_q;
    logic [STATUS_W-1:0] main_status_q, skid_status_q;

    logic capture;
    logic pop;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    // Bubbles (status bit 0 low) are shifted past but never stored.
    assign capture = egress_can_accept(state_q) && pipe_status_i[0];
    assign pop     = egress_has_data(state_q) && m_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (capture) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (capture && pop) begin
                    load_main_in = 1'b1;
                end else if (capture) begin
                    state_d      = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_data_q   <= pipe_data_i;
            main_status_q <= pipe_status_i;
        end else if (load_main_skid) begin
            main_data_q   <= skid_data_q;
            main_status_q <= skid_status_q;
        end
        if (load_skid_in) begin
            skid_data_q   <= pipe_data_i;
            skid_status_q <= pipe_status_i;
        end
    end

    assign pipe_shift_en_o = egress_can_accept(state_q);
    assign m_valid_o       = egress_has_data(state_q);
    assign m_data_o        = main_data_q;
    assign m_status_o      = main_status_q;

endmodule : pipe_stream_egress

// File: tb/tb_pipe_stream_egress.sv
// Scoreboard bench for pipe_stream_egress: upstream entry list feeds an
// expected-order queue; a negedge monitor checks output order and occupancy.
module tb_pipe_stream_egress;

    localparam int DATA_W   = 32;
    localparam int STATUS_W = 1;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } entry_t;

    logic clk;
    logic rst_n;

    pipe_stream_egress_if #(.DATA_W(DATA_W), .STATUS_W(STATUS_W)) u_if ();

    pipe_stream_egress #(.DATA_W(DATA_W), .STATUS_W(STATUS_W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_data_i    (u_if.pipe_data),
        .pipe_status_i  (u_if.pipe_status),
        .pipe_shift_en_o(u_if.pipe_shift_en),
        .m_valid_o      (u_if.m_valid),
        .m_ready_i      (u_if.m_ready),
        .m_data_o       (u_if.m_data),
        .m_status_o     (u_if.m_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    entry_t      up_q[$];
    logic [31:0] exp_q[$];
    int          pop_cyc_q[$];
    int          occ = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: buffer occupancy model plus in-order scoreboard.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            logic cap, pop;
            cyc++;
            chk("m_valid_vs_occ", 64'(u_if.m_valid), 64'(occ > 0));
            chk("shift_en_vs_occ", 64'(u_if.pipe_shift_en), 64'(occ < 2));
            if (prev_stall) begin
                chk("stall_valid_held", 64'(u_if.m_valid), 64'd1);
                chk("stall_data_held", 64'(u_if.m_data), 64'(prev_data));
            end
            cap = u_if.pipe_shift_en && u_if.pipe_status[0];
            pop = u_if.m_valid && u_if.m_ready;
            if (pop) begin
                chk("m_status_bit0", 64'(u_if.m_status[0]), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("pop_with_empty_scoreboard", 64'(u_if.m_data), 64'hDEAD_0000_0000);
                end else begin
                    chk("m_data_order", 64'(u_if.m_data), 64'(exp_q.pop_front()));
                end
                pop_cyc_q.push_back(cyc);
            end
            prev_stall = u_if.m_valid && !u_if.m_ready;
            prev_data  = u_if.m_data;
            occ = occ + int'(cap) - int'(pop);
        end
    end

    // One clock of stimulus; rmode 0/1 fixes m_ready, 2 randomises it.
    task automatic step(input int rmode);
        u_if.m_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
        if (up_q.size() > 0) begin
            u_if.pipe_status = up_q[0].v;
            u_if.pipe_data   = up_q[0].d;
        end else begin
            u_if.pipe_status = 1'b0;
            u_if.pipe_data   = $urandom;
        end
        @(negedge clk);
        #1;
        if (u_if.pipe_shift_en && up_q.size() > 0) begin
            entry_t e;
            e = up_q.pop_front();
            if (e.v) exp_q.push_back(e.d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_up(input logic v, input logic [31:0] d);
        entry_t e;
        e.v = v;
        e.d = d;
        up_q.push_back(e);
    endtask

    initial begin
        rst_n            = 1'b0;
        u_if.m_ready     = 1'b0;
        u_if.pipe_status = 1'b0;
        u_if.pipe_data   = '0;
        #3;
        chk("reset_m_valid", 64'(u_if.m_valid), 64'd0);
        chk("reset_shift_en", 64'(u_if.pipe_shift_en), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Streaming at full rate
        pop_cyc_q.delete();
        for (int i = 1; i <= 16; i++) push_up(1'b1, 32'(i));
        for (int i = 0; i < 20; i++) step(1);
        chk("stream_pop_count", 64'(pop_cyc_q.size()), 64'd16);
        if (pop_cyc_q.size() == 16)
            chk("stream_consecutive", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);

        // Backpressure fills main and skid, holds third entry upstream
        push_up(1'b1, 32'hA);
        push_up(1'b1, 32'hB);
        push_up(1'b1, 32'hC);
        for (int i = 0; i < 3; i++) step(0);
        chk("bp_shift_en_low", 64'(u_if.pipe_shift_en), 64'd0);
        chk("bp_main_is_A", 64'(u_if.m_data), 64'hA);
        chk("bp_C_held_upstream", 64'(up_q.size()), 64'd1);
        for (int i = 0; i < 6; i++) step(1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Bubbles are discarded
        pop_cyc_q.delete();
        push_up(1'b1, 32'd1);
        push_up(1'b0, 32'd2);
        push_up(1'b1, 32'd3);
        push_up(1'b0, 32'd4);
        for (int i = 0; i < 8; i++) step(1);
        chk("bubble_pop_count", 64'(pop_cyc_q.size()), 64'd2);

        // Simultaneous capture and pop in ONE
        push_up(1'b1, 32'h5);
        step(0);
        chk("cp_one_main5", 64'(u_if.m_data), 64'h5);
        push_up(1'b1, 32'h6);
        step(1);
        chk("cp_main6", 64'(u_if.m_data), 64'h6);
        chk("cp_valid", 64'(u_if.m_valid), 64'd1);
        chk("cp_state_one", 64'(u_if.pipe_shift_en), 64'd1);
        for (int i = 0; i < 3; i++) step(1);

        // Reset while FULL
        for (int i = 0; i < 3; i++) push_up(1'b1, $urandom);
        for (int i = 0; i < 3; i++) step(0);
        chk("pre_reset_full", 64'(u_if.pipe_shift_en), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_m_valid", 64'(u_if.m_valid), 64'd0);
        chk("async_reset_shift_en", 64'(u_if.pipe_shift_en), 64'd1);
        exp_q.delete();
        up_q.delete();
        occ = 0;
        prev_stall = 1'b0;
        u_if.pipe_status = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_empty", 64'(u_if.m_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            if (up_q.size() < 4) push_up(1'($urandom_range(0, 9) < 6), $urandom);
            step(2);
        end
        for (int i = 0; i < 20; i++) step(1);
        chk("random_drained_upstream", 64'(up_q.size()), 64'd0);
        chk("random_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_stream_egress

// File: doc/pipe_stream_egress.md
PIPE_STREAM_EGRESS -- requirements
Module: pipe_stream_egress

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the data word.
REQ-002 SHALL have parameter STATUS_W, default 1, width of the status word; status bit 0 is the entry-valid flag.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pipe_data_i  input  DATA_W  data at the final stage of the upstream enable-shift pipeline.
REQ-006 SHALL have port pipe_status_i  input  STATUS_W  status at the final pipeline stage; bit 0 = entry valid.
REQ-007 SHALL have port pipe_shift_en_o  output  1  shift enable driven to the upstream pipeline; high = current final-stage entry is consumed on this edge.
REQ-008 SHALL have port m_valid_o  output  1  output stream valid.
REQ-009 SHALL have port m_ready_i  input  1  output stream ready.
REQ-010 SHALL have port m_data_o  output  DATA_W  output stream data.
REQ-011 SHALL have port m_status_o  output  STATUS_W  output stream status, full width, bit 0 always 1 while m_valid_o is high.

Function
REQ-012 SHALL implement a 2-entry skid buffer: a main register (drives m_*) and a skid register.
REQ-013 SHALL use states EMPTY (no entries), ONE (main valid, skid empty), FULL (main and skid valid).
REQ-014 SHALL drive pipe_shift_en_o = (state != FULL), decoded from registered state only; no combinational path from m_ready_i to pipe_shift_en_o.
REQ-015 SHALL define capture as: rising edge with pipe_shift_en_o=1 and pipe_status_i[0]=1; entries with pipe_status_i[0]=0 are bubbles, shifted past and discarded.
REQ-016 SHALL define pop as: rising edge with m_valid_o=1 and m_ready_i=1.
REQ-017 SHALL drive m_valid_o = (state != EMPTY), from registered state.
REQ-018 Transitions: EMPTY+capture -> ONE (main <= input); EMPTY+no capture -> EMPTY.
REQ-019 Transitions: ONE+capture+pop -> ONE (main <= input); ONE+capture only -> FULL (skid <= input); ONE+pop only -> EMPTY; ONE+neither -> ONE.
REQ-020 Transitions: FULL+pop -> ONE (main <= skid); FULL+no pop -> FULL; no capture possible in FULL.
REQ-021 SHALL deliver entries in capture order with no loss or duplication; minimum latency capture-to-m_valid_o is 1 cycle.
REQ-022 SHALL hold m_data_o/m_status_o stable while m_valid_o=1 and m_ready_i=0.
REQ-023 SHALL sustain one entry per cycle when m_ready_i is held high and the pipeline presents valid entries every cycle.
REQ-024 Data and skid registers SHALL NOT be reset; only state (and therefore valids) is reset.

Reset
REQ-025 On rst_n low, state SHALL go to EMPTY immediately (asynchronously): m_valid_o=0, pipe_shift_en_o=1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries; m_data_o/m_status_o are don't-care while m_valid_o=0.
REQ-027 First capture after release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-028 The state enum (EMPTY, ONE, FULL) SHALL be a typedef in the shared rtl_utils package, 2-bit encoding.
REQ-029 Block SHALL be a single module with no sub-modules; upstream pipeline is instantiated by the integrator, not inside this block.

Verification
REQ-030 Reset: rst_n low mid-stream with FULL state -> same cycle m_valid_o=0, pipe_shift_en_o=1; after release, state EMPTY.
REQ-031 Streaming: m_ready_i=1, valid entries 0x01..0x10 on consecutive cycles -> m_data_o outputs 0x01..0x10 on 16 consecutive cycles, pipe_shift_en_o stays 1.
REQ-032 Backpressure: m_ready_i=0, entries 0xA,0xB,0xC presented -> 0xA in main, 0xB in skid, pipe_shift_en_o=0, 0xC held upstream; m_ready_i=1 -> outputs 0xA,0xB,0xC in order.
REQ-033 Bubbles: pipe_status_i[0] alternating 1/0 with data 1,2,3,4 -> only 1 and 3 appear on m_data_o.
REQ-034 Simultaneous capture+pop in ONE: main=0x5, input 0x6, m_ready_i=1 -> next cycle state ONE, m_data_o=0x6.
REQ-035 Random: random m_ready_i and valid pattern, 10k cycles -> scoreboard order/count match, m_data_o stable under stall, no capture while pipe_shift_en_o=0.
